// File: rtl/rob_core_pkg.sv
// Shared types and constants for the reorder buffer core.
// Used by rob_core (top) and rob_ptr (wrap-bit pointer).
package rob_core_pkg;

    // Tag width for the default 16-entry ROB.
    localparam int ROB_SIZE_BITS = 4;
    localparam int RD_W          = 6;
    localparam int PC_W          = 32;
    localparam int LANES         = 2;

    // One ROB slot: status bits plus the payload handed back at retire.
    typedef struct packed {
        logic            valid;
        logic            done;
        logic [RD_W-1:0] rd;
        logic [RD_W-1:0] rd_old;
        logic [PC_W-1:0] pc;
    } robEntry;

    // Payload presented by one dispatch lane.
    typedef struct packed {
        logic [RD_W-1:0] rd;
        logic [RD_W-1:0] rd_old;
        logic [PC_W-1:0] pc;
    } disp_lane_t;

    // Fields presented by one retire lane.
    typedef struct packed {
        logic            valid;
        logic [RD_W-1:0] rd;
        logic [RD_W-1:0] rd_old;
        logic [PC_W-1:0] pc;
    } ret_lane_t;

    // Number of set bits in a two-lane mask (0, 1 or 2).
    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

endpackage

// File: rtl/rob_core_ptr.sv
// rob_ptr: head/tail pointer with one extra wrap bit.
// Advances by 0, 1 or 2 per cycle; the MSB toggles on every pass
// through the ring so equal indices can be told apart as full/empty.
module rob_ptr
    import rob_core_pkg::*;
#(
    parameter int TAG_W = ROB_SIZE_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic [1:0]       i_inc,
    output logic [TAG_W:0]   o_ptr
);

    logic [TAG_W:0] r_ptr;

    // Pointer register; ring size is a power of two so plain addition wraps.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) r_ptr <= '0;
        else                 r_ptr <= r_ptr + (TAG_W+1)'(i_inc);
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/rob_core.sv
// rob_core: two-wide dispatch / two-wide retire reorder buffer.
// Optional feature macro: ROB_FLUSH_EN adds a 'flush' input that empties
// the ROB at the next edge and overrides dispatch, completion and retire.
module rob_core
    import rob_core_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int NUM_CPL = 3,
    parameter int TAG_W   = $clog2(DEPTH)
) (
    input  logic                          clk,
    input  logic                          rst_n,
`ifdef ROB_FLUSH_EN
    input  logic                          flush,
`endif
    input  logic [LANES-1:0]              disp_valid,
    input  logic [LANES-1:0][RD_W-1:0]    disp_rd,
    input  logic [LANES-1:0][RD_W-1:0]    disp_rd_old,
    input  logic [LANES-1:0][PC_W-1:0]    disp_pc,
    output logic                          disp_ready,
    output logic [LANES-1:0][TAG_W-1:0]   disp_rob_num,
    input  logic [NUM_CPL-1:0]            cpl_valid,
    input  logic [NUM_CPL-1:0][TAG_W-1:0] cpl_rob_num,
    output logic [LANES-1:0]              ret_valid,
    output logic [LANES-1:0][RD_W-1:0]    ret_rd,
    output logic [LANES-1:0][RD_W-1:0]    ret_rd_old,
    output logic [LANES-1:0][PC_W-1:0]    ret_pc,
    output logic                          full,
    output logic                          empty,
    output logic [TAG_W:0]                count
);

    logic                 w_flush;
    logic [TAG_W:0]       w_head;
    logic [TAG_W:0]       w_tail;
    logic [TAG_W:0]       w_count;
    logic                 w_ready;
    logic [1:0]           w_alloc;
    logic [1:0]           w_ret;
    logic [TAG_W-1:0]     w_h0, w_h1, w_t0, w_t1;
    logic [DEPTH-1:0]     w_cpl_hit;
    robEntry              w_hent [LANES];
    disp_lane_t           w_dl   [LANES];
    ret_lane_t            w_rl   [LANES];

    robEntry              r_ent  [DEPTH];

`ifdef ROB_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    // Pointers: tail moves by the accepted dispatch count, head by retires.
    rob_ptr #(.TAG_W(TAG_W)) u_tail (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_flush),
        .i_inc (pop2(w_alloc)),
        .o_ptr (w_tail)
    );

    rob_ptr #(.TAG_W(TAG_W)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_flush),
        .i_inc (pop2(w_ret)),
        .o_ptr (w_head)
    );

    // Occupancy comes straight from the wrap-bit pointer difference.
    assign w_count = w_tail - w_head;
    // Two free slots are always required so a dual dispatch never overruns.
    assign w_ready = (w_count <= (TAG_W+1)'(DEPTH - 2));
    assign w_alloc = w_ready ? disp_valid : 2'b00;

    // Slot indices: lane 1 takes tail only when lane 0 is idle.
    assign w_t0 = w_tail[TAG_W-1:0];
    assign w_t1 = w_t0 + TAG_W'(disp_valid[0]);
    assign w_h0 = w_head[TAG_W-1:0];
    assign w_h1 = w_h0 + TAG_W'(1);

    assign w_hent[0] = r_ent[w_h0];
    assign w_hent[1] = r_ent[w_h1];

    // Retire in order: lane 1 only behind a retiring lane 0.
    always_comb begin
        w_ret    = 2'b00;
        w_ret[0] = w_hent[0].valid & w_hent[0].done & ~w_flush;
        w_ret[1] = w_ret[0] & w_hent[1].valid & w_hent[1].done;
    end

    // Completion decode: any port naming a valid entry marks it done.
    always_comb begin
        w_cpl_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int p = 0; p < NUM_CPL; p++) begin
                if (cpl_valid[p] && (cpl_rob_num[p] == TAG_W'(i)) && r_ent[i].valid)
                    w_cpl_hit[i] = 1'b1;
            end
        end
    end

    // Unpack dispatch payload per lane.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_dl[l].rd     = disp_rd[l];
            w_dl[l].rd_old = disp_rd_old[l];
            w_dl[l].pc     = disp_pc[l];
        end
    end

    // Entry state: completion, then retire clear, then allocation.
    // Allocated slots are free by construction so they never collide with
    // retiring ones; payloads are left unreset.
    always_ff @(posedge clk) begin
        if (!rst_n || w_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i].valid <= 1'b0;
                r_ent[i].done  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_cpl_hit[i])
                    r_ent[i].done <= 1'b1;
                if ((w_ret[0] && w_h0 == TAG_W'(i)) || (w_ret[1] && w_h1 == TAG_W'(i))) begin
                    r_ent[i].valid <= 1'b0;
                    r_ent[i].done  <= 1'b0;
                end
                if (w_alloc[0] && w_t0 == TAG_W'(i)) begin
                    r_ent[i].valid  <= 1'b1;
                    r_ent[i].done   <= 1'b0;
                    r_ent[i].rd     <= w_dl[0].rd;
                    r_ent[i].rd_old <= w_dl[0].rd_old;
                    r_ent[i].pc     <= w_dl[0].pc;
                end else if (w_alloc[1] && w_t1 == TAG_W'(i)) begin
                    r_ent[i].valid  <= 1'b1;
                    r_ent[i].done   <= 1'b0;
                    r_ent[i].rd     <= w_dl[1].rd;
                    r_ent[i].rd_old <= w_dl[1].rd_old;
                    r_ent[i].pc     <= w_dl[1].pc;
                end
            end
        end
    end

    // Retire lanes: fields read as zero whenever the strobe is low,
    // including while reset is held.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_rl[l].valid  = w_ret[l] & rst_n;
            w_rl[l].rd     = w_rl[l].valid ? w_hent[l].rd     : '0;
            w_rl[l].rd_old = w_rl[l].valid ? w_hent[l].rd_old : '0;
            w_rl[l].pc     = w_rl[l].valid ? w_hent[l].pc     : '0;
            ret_valid[l]   = w_rl[l].valid;
            ret_rd[l]      = w_rl[l].rd;
            ret_rd_old[l]  = w_rl[l].rd_old;
            ret_pc[l]      = w_rl[l].pc;
        end
    end

    // Status outputs, held at their idle values while reset is asserted.
    assign disp_ready      = ~rst_n | w_ready;
    assign disp_rob_num[0] = rst_n ? w_t0 : '0;
    assign disp_rob_num[1] = rst_n ? w_t1 : '0;
    assign count           = rst_n ? w_count : '0;
    assign empty           = ~rst_n | (w_count == '0);
    assign full            = rst_n & (w_count == (TAG_W+1)'(DEPTH));

endmodule

// File: tb/tb_rob_core.sv
// Self-checking bench for rob_core (DEPTH=16, 3 completion ports).
// Directed table, fill/drop, random traffic and a full-rate wrap run are
// checked against a queue model of in-flight instructions.
module tb_rob_core;

    localparam int DEPTH = 16;
    localparam int TW    = 4;

    logic             clk, rst_n, flush;
    logic [1:0]       disp_valid;
    logic [1:0][5:0]  disp_rd, disp_rd_old;
    logic [1:0][31:0] disp_pc;
    logic             disp_ready;
    logic [1:0][3:0]  disp_rob_num;
    logic [2:0]       cpl_valid;
    logic [2:0][3:0]  cpl_rob_num;
    logic [1:0]       ret_valid;
    logic [1:0][5:0]  ret_rd, ret_rd_old;
    logic [1:0][31:0] ret_pc;
    logic             full, empty;
    logic [4:0]       count;

    rob_core dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef ROB_FLUSH_EN
        .flush        (flush),
`endif
        .disp_valid   (disp_valid),
        .disp_rd      (disp_rd),
        .disp_rd_old  (disp_rd_old),
        .disp_pc      (disp_pc),
        .disp_ready   (disp_ready),
        .disp_rob_num (disp_rob_num),
        .cpl_valid    (cpl_valid),
        .cpl_rob_num  (cpl_rob_num),
        .ret_valid    (ret_valid),
        .ret_rd       (ret_rd),
        .ret_rd_old   (ret_rd_old),
        .ret_pc       (ret_pc),
        .full         (full),
        .empty        (empty),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: in-flight instructions in order
    typedef struct {
        int          tag;
        logic [31:0] pc;
        logic [5:0]  rd;
        logic [5:0]  rd_old;
        bit          done;
    } m_t;

    m_t          q[$];
    int          m_tail = 0;
    logic [31:0] pc_ctr = 32'h1000;
    int          obs_r0, obs_r1, obs_ret;

    // One clock: drive at negedge, check just after, model update after posedge.
    task automatic cyc(input logic [1:0] dv, input logic [2:0] cv,
                       input logic [2:0][3:0] ct, input logic fl);
        int          n, nret;
        int          e_r0, e_r1;
        logic        e_ready;
        logic [1:0]  e_ret;
        logic [31:0] e_pc;
        logic [5:0]  e_rd, e_rdo;
        m_t          ne;
        disp_valid     = dv;
        cpl_valid      = cv;
        cpl_rob_num    = ct;
        flush          = fl;
        disp_pc[0]     = pc_ctr;
        disp_pc[1]     = pc_ctr + 32'd4;
        disp_rd[0]     = 6'($urandom);
        disp_rd[1]     = 6'($urandom);
        disp_rd_old[0] = 6'($urandom);
        disp_rd_old[1] = 6'($urandom);
        #1;
        n       = q.size();
        e_ready = (DEPTH - n) >= 2;
        e_r0    = m_tail;
        e_r1    = dv[0] ? (m_tail + 1) % DEPTH : m_tail;
        e_ret   = 2'b00;
        if (!fl && n >= 1 && q[0].done) begin
            e_ret[0] = 1'b1;
            if (n >= 2 && q[1].done) e_ret[1] = 1'b1;
        end
        chk("ready", 32'(disp_ready), 32'(e_ready));
        chk("count", 32'(count), 32'(n));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full_empty_excl", 32'(full & empty), 32'd0);
        chk("rob0", 32'(disp_rob_num[0]), 32'(e_r0));
        chk("rob1", 32'(disp_rob_num[1]), 32'(e_r1));
        chk("ret_valid", 32'(ret_valid), 32'(e_ret));
        for (int l = 0; l < 2; l++) begin
            e_pc = '0; e_rd = '0; e_rdo = '0;
            if (e_ret[l]) begin
                e_pc = q[l].pc; e_rd = q[l].rd; e_rdo = q[l].rd_old;
            end
            chk($sformatf("ret_pc%0d", l), ret_pc[l], e_pc);
            chk($sformatf("ret_rd%0d", l), 32'(ret_rd[l]), 32'(e_rd));
            chk($sformatf("ret_rd_old%0d", l), 32'(ret_rd_old[l]), 32'(e_rdo));
        end
        obs_r0  = int'(disp_rob_num[0]);
        obs_r1  = int'(disp_rob_num[1]);
        obs_ret += int'(ret_valid[0]) + int'(ret_valid[1]);
        @(posedge clk);
        if (fl) begin
            q.delete();
            m_tail = 0;
        end else begin
            nret = int'(e_ret[0]) + int'(e_ret[1]);
            repeat (nret) void'(q.pop_front());
            for (int p = 0; p < 3; p++)
                if (cv[p])
                    for (int j = 0; j < q.size(); j++)
                        if (q[j].tag == int'(ct[p])) q[j].done = 1'b1;
            if (e_ready)
                for (int l = 0; l < 2; l++)
                    if (dv[l]) begin
                        ne.tag = m_tail; ne.pc = disp_pc[l]; ne.rd = disp_rd[l];
                        ne.rd_old = disp_rd_old[l]; ne.done = 1'b0;
                        q.push_back(ne);
                        m_tail = (m_tail + 1) % DEPTH;
                    end
        end
        pc_ctr += 32'd8;
        @(negedge clk);
    endtask

    // Reset with traffic applied; idle outputs are checked while held.
    task automatic do_reset();
        rst_n = 1'b0; disp_valid = 2'b11; cpl_valid = 3'b111; flush = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ready", 32'(disp_ready), 32'd1);
        chk("rst_ret_valid", 32'(ret_valid), 32'd0);
        chk("rst_rob_num", 32'(disp_rob_num), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ret_pc", ret_pc[0] | ret_pc[1], 32'd0);
        chk("rst_ret_rd", 32'({ret_rd, ret_rd_old}), 32'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1; disp_valid = 2'b00; cpl_valid = 3'b000;
        q.delete();
        m_tail = 0;
    endtask

    // ---------------- directed table
    typedef struct {
        logic [1:0]  dv;
        logic [5:0]  rd0, rd1;
        logic [31:0] pc0, pc1;
        logic        cv;
        int          cport;
        logic [3:0]  ctag;
        logic [1:0]  e_ret;
        logic [3:0]  e_r0, e_r1;
        logic [4:0]  e_cnt;
        logic [5:0]  e_rd0, e_rd1;
        logic [31:0] e_pc0, e_pc1;
    } vec_t;

    function automatic vec_t mk(logic [1:0] dv, logic [5:0] rd0, logic [5:0] rd1,
                                logic [31:0] pc0, logic [31:0] pc1, logic cv, int cport,
                                logic [3:0] ctag, logic [1:0] e_ret, logic [3:0] e_r0,
                                logic [3:0] e_r1, logic [4:0] e_cnt, logic [5:0] e_rd0,
                                logic [5:0] e_rd1, logic [31:0] e_pc0, logic [31:0] e_pc1);
        vec_t v;
        v.dv = dv; v.rd0 = rd0; v.rd1 = rd1; v.pc0 = pc0; v.pc1 = pc1;
        v.cv = cv; v.cport = cport; v.ctag = ctag; v.e_ret = e_ret;
        v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_cnt = e_cnt;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_pc0 = e_pc0; v.e_pc1 = e_pc1;
        return v;
    endfunction

    vec_t tbl [10];

    logic [2:0][3:0] ct;
    int saw15, wrapped, nt0, nt1;

    initial begin
        rst_n = 1'b0; flush = 1'b0; disp_valid = '0; cpl_valid = '0;
        cpl_rob_num = '0; disp_rd = '0; disp_rd_old = '0; disp_pc = '0;
        @(negedge clk);
        do_reset();

        // dual dispatch, out-of-order completion, paired retire, lone lane 1
        tbl[0] = mk(2'b11, 6'd5, 6'd6, 32'h100, 32'h104, 1'b0, 0, 4'd0, 2'b00, 4'd0, 4'd1, 5'd0, 6'd0, 6'd0, 32'h0, 32'h0);
        tbl[1] = mk(2'b00, 6'd0, 6'd0, 32'h0,   32'h0,   1'b1, 0, 4'd1, 2'b00, 4'd2, 4'd2, 5'd2, 6'd0, 6'd0, 32'h0, 32'h0);
        tbl[2] = mk(2'b00, 6'd0, 6'd0, 32'h0,   32'h0,   1'b0, 0, 4'd0, 2'b00, 4'd2, 4'd2, 5'd2, 6'd0, 6'd0, 32'h0, 32'h0);
        tbl[3] = mk(2'b00, 6'd0, 6'd0, 32'h0,   32'h0,   1'b1, 1, 4'd0, 2'b00, 4'd2, 4'd2, 5'd2, 6'd0, 6'd0, 32'h0, 32'h0);
        tbl[4] = mk(2'b00, 6'd0, 6'd0, 32'h0,   32'h0,   1'b0, 0, 4'd0, 2'b11, 4'd2, 4'd2, 5'd2, 6'd5, 6'd6, 32'h100, 32'h104);
        tbl[5] = mk(2'b10, 6'd0, 6'd7, 32'h0,   32'h108, 1'b0, 0, 4'd0, 2'b00, 4'd2, 4'd2, 5'd0, 6'd0, 6'd0, 32'h0, 32'h0);
        tbl[6] = mk(2'b00, 6'd0, 6'd0, 32'h0,   32'h0,   1'b0, 0, 4'd0, 2'b00, 4'd3, 4'd3, 5'd1, 6'd0, 6'd0, 32'h0, 32'h0);
        tbl[7] = mk(2'b00, 6'd0, 6'd0, 32'h0,   32'h0,   1'b1, 2, 4'd2, 2'b00, 4'd3, 4'd3, 5'd1, 6'd0, 6'd0, 32'h0, 32'h0);
        tbl[8] = mk(2'b00, 6'd0, 6'd0, 32'h0,   32'h0,   1'b0, 0, 4'd0, 2'b01, 4'd3, 4'd3, 5'd1, 6'd7, 6'd0, 32'h108, 32'h0);
        tbl[9] = mk(2'b00, 6'd0, 6'd0, 32'h0,   32'h0,   1'b0, 0, 4'd0, 2'b00, 4'd3, 4'd3, 5'd0, 6'd0, 6'd0, 32'h0, 32'h0);

        for (int i = 0; i < 10; i++) begin
            disp_valid     = tbl[i].dv;
            disp_rd[0]     = tbl[i].rd0;
            disp_rd[1]     = tbl[i].rd1;
            disp_rd_old    = '0;
            disp_pc[0]     = tbl[i].pc0;
            disp_pc[1]     = tbl[i].pc1;
            cpl_valid      = '0;
            cpl_rob_num    = '0;
            if (tbl[i].cv) begin
                cpl_valid[tbl[i].cport]   = 1'b1;
                cpl_rob_num[tbl[i].cport] = tbl[i].ctag;
            end
            #1;
            chk($sformatf("tbl%0d_ret_valid", i), 32'(ret_valid), 32'(tbl[i].e_ret));
            chk($sformatf("tbl%0d_rob0", i), 32'(disp_rob_num[0]), 32'(tbl[i].e_r0));
            chk($sformatf("tbl%0d_rob1", i), 32'(disp_rob_num[1]), 32'(tbl[i].e_r1));
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d_ret_rd0", i), 32'(ret_rd[0]), 32'(tbl[i].e_rd0));
            chk($sformatf("tbl%0d_ret_rd1", i), 32'(ret_rd[1]), 32'(tbl[i].e_rd1));
            chk($sformatf("tbl%0d_ret_pc0", i), ret_pc[0], tbl[i].e_pc0);
            chk($sformatf("tbl%0d_ret_pc1", i), ret_pc[1], tbl[i].e_pc1);
            @(posedge clk); @(negedge clk);
        end

        // fill to 14, then to full, then a dropped dispatch
        do_reset();
        repeat (7) cyc(2'b11, 3'b000, '0, 1'b0);
        #1;
        chk("fill14_ready", 32'(disp_ready), 32'd1);
        chk("fill14_count", 32'(count), 32'd14);
        cyc(2'b11, 3'b000, '0, 1'b0);
        #1;
        chk("fill16_full", 32'(full), 32'd1);
        chk("fill16_ready", 32'(disp_ready), 32'd0);
        cyc(2'b11, 3'b000, '0, 1'b0);
        #1;
        chk("drop_tail", 32'(disp_rob_num[0]), 32'd0);
        chk("drop_count", 32'(count), 32'd16);
        @(negedge clk);

        // reset while full, then random traffic
        do_reset();
        for (int k = 0; k < 300; k++) begin
            for (int p = 0; p < 3; p++) begin
                if (q.size() > 0 && $urandom_range(3, 0) != 0)
                    ct[p] = 4'(q[$urandom_range(q.size() - 1, 0)].tag);
                else
                    ct[p] = 4'($urandom);
            end
            cyc(2'($urandom), 3'($urandom), ct, 1'b0);
        end

        // full rate: 2 dispatched, 2 completed, 2 retired per cycle
        do_reset();
        saw15 = 0; wrapped = 0; obs_ret = 0; ct = '0;
        for (int k = 0; k < 23; k++) begin
            nt0 = m_tail;
            nt1 = (m_tail + 1) % DEPTH;
            cyc((k < 20) ? 2'b11 : 2'b00, (k > 0 && k <= 20) ? 3'b011 : 3'b000, ct, 1'b0);
            if (obs_r1 == 15 && k < 20) saw15 = 1;
            else if (saw15 != 0 && obs_r0 == 0 && k < 20) wrapped = 1;
            ct = '0;
            ct[0] = 4'(nt0);
            ct[1] = 4'(nt1);
        end
        chk("stream_tag_wrap", 32'(wrapped), 32'd1);
        chk("stream_retired", 32'(obs_ret), 32'd40);

`ifdef ROB_FLUSH_EN
        do_reset();
        repeat (3) cyc(2'b11, 3'b000, '0, 1'b0);
        ct = '0;
        cyc(2'b11, 3'b001, ct, 1'b1);
        #1;
        chk("flush_empty", 32'(empty), 32'd1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_rob0", 32'(disp_rob_num[0]), 32'd0);
        @(negedge clk);
        ct[0] = 4'd3;
        cyc(2'b00, 3'b001, ct, 1'b0);
        cyc(2'b00, 3'b000, '0, 1'b0);
        cyc(2'b11, 3'b000, '0, 1'b0);
        cyc(2'b00, 3'b000, '0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule

// File: doc/rob_core.md
ROB_CORE -- requirements
Module: rob_core

Interface
REQ-001 SHALL have parameter DEPTH, default 16, number of ROB entries; power of two, minimum 4.
REQ-002 SHALL have parameter NUM_CPL, default 3, number of completion ports (alu1, alu2, mem).
REQ-003 SHALL have parameter TAG_W, default $clog2(DEPTH), ROB number width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port disp_valid  input  2  per-lane dispatch request; lane 0 is older.
REQ-007 SHALL have port disp_rd / disp_rd_old  input  2x6  per-lane physical destination and previous mapping.
REQ-008 SHALL have port disp_pc  input  2x32  per-lane instruction PC.
REQ-009 SHALL have port disp_ready  output  1  at least two entries free.
REQ-010 SHALL have port disp_rob_num  output  2xTAG_W  tag assigned per lane this cycle.
REQ-011 SHALL have port cpl_valid / cpl_rob_num  input  NUM_CPL / NUM_CPLxTAG_W  completion notifications.
REQ-012 SHALL have port ret_valid  output  2  per-lane retire strobe; lane 0 is older.
REQ-013 SHALL have port ret_rd / ret_rd_old / ret_pc  output  2x6 / 2x6 / 2x32  retired entry fields; rd_old returns to the free list.
REQ-014 SHALL have ports full / empty  output  1 each  occupancy flags; count  output  TAG_W+1  occupied entries.

Function
REQ-015 SHALL hold head/tail pointers of TAG_W+1 bits; the MSB distinguishes full from empty when the pointers wrap.
REQ-016 Dispatch SHALL allocate only when disp_ready=1; valid lanes take consecutive tags from tail in lane order, so a lone lane-1 request takes tail.
REQ-017 disp_rob_num SHALL be combinational from tail: lane 0 = tail, lane 1 = tail+1 if lane 0 is valid, else tail (mod DEPTH).
REQ-018 An allocated entry SHALL become valid with done=0 on the next edge.
REQ-019 Completion SHALL set done on the next edge; completion to an invalid entry is ignored; a repeated completion is idempotent; multiple ports may hit distinct or identical tags in the same cycle.
REQ-020 Retire SHALL be combinational from registered state: ret_valid[0]=valid&done at head; ret_valid[1] additionally requires ret_valid[0] and valid&done at head+1.
REQ-021 Retired entries SHALL be invalidated and head advanced by the retire count on the same edge.
REQ-022 A completion arriving in cycle N SHALL make the entry retirable no earlier than cycle N+1.
REQ-023 count SHALL update as count + allocated - retired; simultaneous dispatch and retire in one cycle is legal.
REQ-024 disp_ready SHALL use the registered count (DEPTH-count >= 2), not the same-cycle retire count.
REQ-025 Dispatch while disp_ready=0 SHALL be dropped without any state change.

Reset
REQ-026 With rst_n=0 at an edge, head=tail=0, count=0, all valid=0 and done=0, mid-operation included; entry payloads need not be reset.
REQ-027 During and after reset: empty=1, full=0, disp_ready=1, ret_valid=0, disp_rob_num=0; ret_rd, ret_rd_old and ret_pc are 0 while their ret_valid bit is 0.

Configuration
REQ-028 With ROB_FLUSH_EN defined, SHALL add an input flush (1 bit); flush=1 at an edge clears all valid bits, sets head=tail=0 and count=0, and overrides same-cycle dispatch, completion and retire; ret_valid is forced to 0 while flush=1.
REQ-029 Without ROB_FLUSH_EN, the flush port SHALL be absent and only reset clears the ROB.

Structure
REQ-030 The shared package SHALL hold ROB_SIZE_BITS (= TAG_W default), a robEntry struct {valid, done, rd, rd_old, pc}, and the dispatch/retire lane structs.
REQ-031 The wrap-bit pointer arithmetic SHALL be in one sub-module, rob_ptr (increment by 0/1/2 with wrap), instanced for head and tail.

Verification
REQ-032 Reset, then dispatch 2 lanes (rd 5/6, pc 0x100/0x104) -> disp_rob_num 0/1, count=2 next cycle, ret_valid=0.
REQ-033 Complete tag 1 then tag 0 in later cycles -> no retire after tag 1; both retire together one cycle after tag 0 completes, ret_rd 5/6, lane order kept.
REQ-034 Fill to count=14 with DEPTH=16 -> disp_ready=1; dispatch 2 more -> full=1, disp_ready=0; a third dispatch is dropped and tail is unchanged.
REQ-035 Run 40 instructions at 2 dispatched and 2 retired per cycle -> tags wrap 15->0; full and empty never both 1; in-order retire PCs match dispatch order.
REQ-036 With ROB_FLUSH_EN, 6 entries in flight, flush plus same-cycle dispatch and completion -> next cycle empty=1, count=0, disp_rob_num 0; a stale completion to tag 3 is ignored.
